// File: rtl/fetch_pkg.sv
// Shared constants and types for the rv32i instruction fetch path.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int INSTR_WIDTH = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instruction;
    logic [XLEN-1:0]        pc;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_prefetch_buffer_sync_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; empty gating hides stale words.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instruction_prefetch_buffer.sv
// Sequential instruction prefetcher feeding decode through a small FIFO,
// with single-cycle memory latency and redirect flush.
module instruction_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        read_enable,
  output logic [31:0] read_address,
  input  logic [31:0] read_value,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instruction_valid,
  output logic [31:0] instruction,
  output logic [31:0] instruction_pc,
  input  logic        instruction_ready
);

  import fetch_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic            running;
  logic            inflight;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;
  logic [$bits(fetch_entry_t)-1:0] head_bits;
  logic            fifo_empty;
  logic            unused_full;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     occupancy;
  logic            push;
  logic            pop;
  logic            unused_redirect_bits;

  assign unused_redirect_bits = ^redirect_pc[1:0];

  // An in-flight word already owns a FIFO slot.
  assign occupancy   = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign read_enable = running && !redirect_valid
                    && (occupancy < (CW+1)'(DEPTH));
  assign read_address = fetch_pc;

  assign push = inflight && !redirect_valid;
  assign pop  = instruction_valid && instruction_ready && !redirect_valid;
  assign push_entry = '{instruction: read_value, pc: inflight_pc};

  assign head              = fifo_empty ? '0 : head_bits;
  assign instruction_valid = !fifo_empty;
  assign instruction       = head.instruction;
  assign instruction_pc    = head.pc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      running     <= 1'b0;
      inflight    <= 1'b0;
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
    end else begin
      running <= 1'b1;
      if (redirect_valid) begin
        inflight <= 1'b0;
        fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else if (read_enable) begin
        inflight    <= 1'b1;
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + PC_STEP;
      end else begin
        inflight <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock  (clock),
    .reset_n(reset_n),
    .push   (push),
    .pop    (pop),
    .flush  (redirect_valid),
    .wdata  (push_entry),
    .rdata  (head_bits),
    .full   (unused_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

endmodule

// File: doc/instruction_prefetch_buffer.md
# instruction_prefetch_buffer

Sequential instruction prefetcher between instruction memory and the decode stage of the rv32i core. It issues word reads to memory at consecutive PCs and captures each returned instruction with its PC in a small FIFO. It presents the FIFO head to decode with a valid/ready handshake. A redirect from execute (branch/jump) flushes all buffered and in-flight instructions and restarts fetch at the new PC.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clock  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- read_enable  output  1  memory read request this cycle
- read_address  output  32  word address of request; bits [1:0] always 0
- read_value  input  32  instruction word; valid exactly 1 cycle after read_enable
- redirect_valid  input  1  flush and restart fetch
- redirect_pc  input  32  restart address; bits [1:0] ignored and forced to 0
- instruction_valid  output  1  FIFO head valid
- instruction  output  32  FIFO head instruction word
- instruction_pc  output  32  PC of FIFO head
- instruction_ready  input  1  decode accepts head this cycle

## Operation
- State: fetch_pc, FIFO (read/write pointers, occupancy count of width clog2(DEPTH+1)), inflight flag, inflight_pc, running flag.
- No FSM beyond these pointers, counters and flags.
- running: cleared by reset, set on the first clock edge after reset_n rises.
- Issue rule: read_enable = running && !redirect_valid && (count + inflight) < DEPTH.
  - Pop in the same cycle earns no credit.
  - read_address = fetch_pc.
  - On issue: fetch_pc += 4 (wraps modulo 2^32), inflight ← 1, inflight_pc ← fetch_pc.
  - Without issue: inflight ← 0.
- Response capture: in a cycle with inflight = 1 and no redirect_valid, push {read_value, inflight_pc} into the FIFO.
- Pop: on instruction_valid && instruction_ready.
- Push and pop may occur in the same cycle, including when the FIFO is full: count is unchanged and the entry order is preserved.
- Redirect (priority over everything else), at the next edge:
  - FIFO emptied.
  - Any response arriving that cycle is discarded.
  - inflight ← 0.
  - fetch_pc ← {redirect_pc[31:2], 2'b00}.
  - No read is issued in the redirect cycle.
  - A pop handshake in the redirect cycle has no effect.
- Empty FIFO: instruction_valid = 0, and instruction and instruction_pc read 0.

## Timing
- Reset values (asynchronous, held while reset_n low):
  - read_enable 0
  - read_address RESET_PC
  - instruction_valid 0
  - instruction 0
  - instruction_pc 0
- First request: the cycle after the first rising edge with reset_n high.
- Latency:
  - request in cycle N → read_value in N+1 → instruction_valid in N+2.
  - No bypass from read_value to outputs.
- Steady state with instruction_ready = 1 and DEPTH ≥ 4: one instruction per cycle.
- Redirect in cycle R: instruction_valid = 0 in R+1, request at the new PC in R+1, first new instruction valid in R+3.
- Reset mid-operation: all state cleared immediately; fetch restarts at RESET_PC per the first-request rule.
- All outputs are functions of registered state only, except read_enable, which also depends combinationally on redirect_valid.

## Structure
- Package fetch_pkg:
  - XLEN = 32
  - INSTR_WIDTH = 32
  - PC_STEP = 4
  - default RESET_PC
  - typedef fetch_entry_t {instruction, pc}
- Sub-module sync_fifo:
  - parameterised width and DEPTH
  - push/pop/flush inputs
  - full/empty/count outputs
  - instantiated once with fetch_entry_t
- Top level holds the PC, inflight tracking, issue rule and redirect handling.

## Test plan
- Reset release, memory returns read_value = read_address ^ 32'hA5A5_0000, ready = 1 → reads at 0x0, 0x4, 0x8…; instruction_valid first at cycle 2 after the first request; head pairs (0xA5A5_0000, 0x0), (0xA5A5_0004, 0x4) in order, no gaps.
- instruction_ready = 0 from reset → exactly 4 reads (0x0–0xC), read_enable then stays 0, head stays pc 0x0; raise ready → pcs 0x0, 0x4, 0x8, 0xC, 0x10 in order, no loss or duplicate.
- Redirect to 0x100 with 3 entries buffered and 1 in flight → next cycle instruction_valid = 0, in-flight word never appears, read at 0x100, first output pc 0x100 two cycles later.
- redirect_pc = 0x0000_0103 → read_address 0x100; fetch_pc 0xFFFF_FFFC → next read at 0x0 (wrap).
- Full FIFO with push and pop in the same cycle for 10 cycles → count held at DEPTH, PCs strictly sequential.
- reset_n pulsed low mid-stream between edges → outputs drop to reset values immediately; after release, reads restart at RESET_PC.
